raw8_debayer: RTL and testbench



---
 rtl/raw8_debayer.sv | 150 +++++++++++++++
 tb/tb_raw8_debayer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raw8_debayer.sv
// RAW8 Bayer to 24-bit RGB demosaic using a 2x2 window (one line buffer plus two delay registers).
// Optional macro RAW8_DEBAYER_BYPASS_EN adds a per-pixel bypass input that forces gray output.
module raw8_debayer #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int BAYER_ORDER = 0
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        in_valid,
  input  logic [7:0]  in_pixel,
`ifdef RAW8_DEBAYER_BYPASS_EN
  input  logic        bypass,
`endif
  output logic        out_valid,
  output logic [23:0] out_rgb,
  output logic        out_end_of_line,
  output logic        out_end_of_frame
);

  localparam int DATA_W = 8;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam bit BO_X = BAYER_ORDER[0];
  localparam bit BO_Y = BAYER_ORDER[1];

  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W:1];
  endfunction

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          x_last;
  logic          y_last;

  logic [DATA_W-1:0] line_buf [WIDTH];

  logic              vld_p0;
  logic [DATA_W-1:0] cur_p0;
  logic [DATA_W-1:0] up_p0;
  logic [DATA_W-1:0] left_p0;
  logic [DATA_W-1:0] diag_p0;
  logic              px_p0;
  logic              py_p0;
  logic              edge_p0;
  logic              eol_p0;
  logic              eof_p0;
  logic              gray_p0;
  logic [23:0]       rgb_p0;

  // frame_start applies to the pixel presented in the same cycle
  assign pix_x  = frame_start ? '0 : x_cnt;
  assign pix_y  = frame_start ? '0 : y_cnt;
  assign x_last = (pix_x == X_LAST);
  assign y_last = (pix_y == Y_LAST);

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_valid) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : pix_y + 1'b1;
      end else begin
        x_cnt <= pix_x + 1'b1;
        y_cnt <= pix_y;
      end
    end else if (frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end
  end

  // Stage p0: line buffer read-before-write, window shift on accepted pixels only
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (in_valid) begin
      line_buf[pix_x] <= in_pixel;
      up_p0           <= line_buf[pix_x];
      cur_p0          <= in_pixel;
      left_p0         <= cur_p0;
      diag_p0         <= up_p0;
      px_p0           <= pix_x[0] ^ BO_X;
      py_p0           <= pix_y[0] ^ BO_Y;
      edge_p0         <= (pix_x == '0) || (pix_y == '0);
      eol_p0          <= x_last;
      eof_p0          <= x_last && y_last;
    end
  end

`ifdef RAW8_DEBAYER_BYPASS_EN
  logic bypass_p0;

  always_ff @(posedge pixel_clk) begin
    if (in_valid) begin
      bypass_p0 <= bypass;
    end
  end

  assign gray_p0 = edge_p0 || bypass_p0;
`else
  assign gray_p0 = edge_p0;
`endif

  always_comb begin
    rgb_p0 = {cur_p0, cur_p0, cur_p0};
    if (!gray_p0) begin
      case ({py_p0, px_p0})
        2'b00:   rgb_p0 = {cur_p0,  avg2(left_p0, up_p0),  diag_p0};
        2'b01:   rgb_p0 = {left_p0, avg2(cur_p0, diag_p0), up_p0};
        2'b10:   rgb_p0 = {up_p0,   avg2(cur_p0, diag_p0), left_p0};
        default: rgb_p0 = {diag_p0, avg2(left_p0, up_p0),  cur_p0};
      endcase
    end
  end

  // Stage p1: output register; colour holds while no pixel is valid
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      out_valid        <= 1'b0;
      out_rgb          <= '0;
      out_end_of_line  <= 1'b0;
      out_end_of_frame <= 1'b0;
    end else begin
      out_valid        <= vld_p0;
      out_end_of_line  <= vld_p0 && eol_p0;
      out_end_of_frame <= vld_p0 && eof_p0;
      if (vld_p0) begin
        out_rgb <= rgb_p0;
      end
    end
  end

endmodule

// File: tb/tb_raw8_debayer.sv
// Bench for raw8_debayer: 4x4 frames, RGGB and BGGR instances side by side, constant tables
// plus a coordinate-based scoreboard running under all stimulus.
module tb_raw8_debayer;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        in_valid;
  logic [7:0]  in_pixel;
  logic        v0, v1, eol0, eol1, eof0, eof1;
  logic [23:0] rgb0, rgb1;

  always #5 clk = ~clk;

  raw8_debayer #(.WIDTH(W), .HEIGHT(H), .BAYER_ORDER(0)) dut0 (
    .pixel_clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .in_valid(in_valid), .in_pixel(in_pixel),
`ifdef RAW8_DEBAYER_BYPASS_EN
    .bypass(1'b0),
`endif
    .out_valid(v0), .out_rgb(rgb0), .out_end_of_line(eol0), .out_end_of_frame(eof0)
  );

  raw8_debayer #(.WIDTH(W), .HEIGHT(H), .BAYER_ORDER(3)) dut1 (
    .pixel_clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .in_valid(in_valid), .in_pixel(in_pixel),
`ifdef RAW8_DEBAYER_BYPASS_EN
    .bypass(1'b0),
`endif
    .out_valid(v1), .out_rgb(rgb1), .out_end_of_line(eol1), .out_end_of_frame(eof1)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: image indexed by coordinates, colour chosen from Bayer phase
  logic [7:0] img [H][W];

  function automatic logic [23:0] model_rgb(input int x, input int y, input int bo);
    int cur, left, up, diag, r, g, b;
    bit px, py;
    cur = int'(img[y][x]);
    if (x == 0 || y == 0) return {8'(cur), 8'(cur), 8'(cur)};
    left = int'(img[y][x-1]);
    up   = int'(img[y-1][x]);
    diag = int'(img[y-1][x-1]);
    px = (x % 2) != (bo % 2);
    py = (y % 2) != ((bo / 2) % 2);
    if (!px && !py)     begin r = cur;  g = (left + up) / 2;  b = diag; end
    else if (px && !py) begin r = left; g = (cur + diag) / 2; b = up;   end
    else if (!px && py) begin r = up;   g = (cur + diag) / 2; b = left; end
    else                begin r = diag; g = (left + up) / 2;  b = cur;  end
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  typedef struct {
    int          due;
    logic [23:0] rgb0;
    logic [23:0] rgb3;
    logic        eol;
    logic        eof;
  } exp_t;

  typedef struct {
    logic [23:0] rgb0;
    logic [23:0] rgb1;
    logic        eol;
    logic        eof;
  } obs_t;

  exp_t expq[$];
  obs_t obs[$];
  int   cyc = 0;
  int   mx = 0, my = 0;
  bit   rst_edge = 1'b1;
  bit   sb_en = 1'b0;
  logic [23:0] last0 = '0;

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    rst_edge = !reset_n;
    if (!reset_n) begin
      expq.delete();
      mx = 0;
      my = 0;
    end else begin
      if (frame_start) begin
        mx = 0;
        my = 0;
      end
      if (in_valid) begin
        img[my][mx] = in_pixel;
        e.due  = cyc + 1;
        e.rgb0 = model_rgb(mx, my, 0);
        e.rgb3 = model_rgb(mx, my, 3);
        e.eol  = (mx == W - 1);
        e.eof  = (mx == W - 1) && (my == H - 1);
        expq.push_back(e);
        mx = mx + 1;
        if (mx == W) begin
          mx = 0;
          my = (my == H - 1) ? 0 : my + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    obs_t o;
    if (v0 === 1'b1) begin
      o.rgb0 = rgb0; o.rgb1 = rgb1; o.eol = eol0; o.eof = eof0;
      obs.push_back(o);
    end
    if (sb_en) begin
      exp_v = (expq.size() > 0) && (expq[0].due == cyc);
      if (exp_v || v0 === 1'b1) begin
        chk("sb_valid0", 32'(v0), 32'(exp_v));
        chk("sb_valid1", 32'(v1), 32'(exp_v));
        if (exp_v) begin
          chk("sb_rgb_rggb", 32'(rgb0), 32'(expq[0].rgb0));
          chk("sb_rgb_bggr", 32'(rgb1), 32'(expq[0].rgb3));
          chk("sb_eol", 32'({eol0, eol1}), 32'({2{expq[0].eol}}));
          chk("sb_eof", 32'({eof0, eof1}), 32'({2{expq[0].eof}}));
          void'(expq.pop_front());
        end
      end else begin
        if (rst_edge) last0 = '0;
        chk("sb_hold", 32'(rgb0), 32'(last0));
      end
      if (v0 === 1'b1) last0 = rgb0;
    end
  end

  task automatic send(input logic [7:0] p, input logic fs);
    in_valid    = 1'b1;
    frame_start = fs;
    in_pixel    = p;
    @(negedge clk);
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  pix;
    logic [23:0] e0;
    logic [23:0] e3;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] pix [32];
  logic [23:0] ref16 [16];
  int         eof_early;

  initial begin
    reset_n = 1'b0;
    frame_start = 1'b0;
    in_valid = 1'b1;
    in_pixel = 8'h77;

    tbl[0] = '{8'd10, 24'h0A0A0A, 24'h0A0A0A};
    tbl[1] = '{8'd20, 24'h141414, 24'h141414};
    tbl[2] = '{8'd30, 24'h1E1E1E, 24'h1E1E1E};
    tbl[3] = '{8'd40, 24'h282828, 24'h282828};
    tbl[4] = '{8'd50, 24'h323232, 24'h323232};
    tbl[5] = '{8'd60, 24'h0A233C, 24'h3C230A};
    tbl[6] = '{8'd70, 24'h1E2D3C, 24'h3C2D1E};
    tbl[7] = '{8'd80, 24'h1E3750, 24'h50371E};

    // Reset: outputs cleared even with input activity
    idle(3);
    chk("rst_valid", 32'({v0, v1}), 32'd0);
    chk("rst_rgb0", 32'(rgb0), 32'd0);
    chk("rst_rgb1", 32'(rgb1), 32'd0);
    chk("rst_flags", 32'({eol0, eof0, eol1, eof1}), 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    idle(1);
    sb_en = 1'b1;

    // Single pixel latency
    send(8'h5A, 1'b0);
    chk("lat_cycle1_valid", 32'(v0), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(v0), 32'd1);
    chk("lat_rgb", 32'(rgb0), 32'h5A5A5A);
    @(negedge clk);
    chk("lat_cycle3_valid", 32'(v0), 32'd0);
    chk("lat_hold", 32'(rgb0), 32'h5A5A5A);

    // Known frame, both Bayer orders
    obs.delete();
    for (int i = 0; i < 8; i++) send(tbl[i].pix, i == 0);
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
    idle(4);
    chk("tbl_count", 32'(obs.size()), 32'd16);
    if (obs.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("tbl_rggb[%0d]", i), 32'(obs[i].rgb0), 32'(tbl[i].e0));
        chk($sformatf("tbl_bggr[%0d]", i), 32'(obs[i].rgb1), 32'(tbl[i].e3));
      end
    end

    // Saturated input: averaging must not overflow
    obs.delete();
    for (int i = 0; i < 16; i++) send(8'hFF, i == 0);
    idle(4);
    chk("ff_count", 32'(obs.size()), 32'd16);
    foreach (obs[i]) begin
      chk($sformatf("ff_rggb[%0d]", i), 32'(obs[i].rgb0), 32'hFFFFFF);
      chk($sformatf("ff_bggr[%0d]", i), 32'(obs[i].rgb1), 32'hFFFFFF);
    end

    // Two back-to-back frames: line/frame flags and wrap
    obs.delete();
    for (int i = 0; i < 32; i++) pix[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) send(pix[i], i == 0);
    idle(4);
    chk("wrap_count", 32'(obs.size()), 32'd32);
    if (obs.size() == 32) begin
      foreach (obs[i]) begin
        chk($sformatf("wrap_eol[%0d]", i), 32'(obs[i].eol), 32'((i % 4) == 3));
        chk($sformatf("wrap_eof[%0d]", i), 32'(obs[i].eof), 32'(i == 15 || i == 31));
      end
      chk("wrap_out17_gray", 32'(obs[16].rgb0), 32'({3{pix[16]}}));
      for (int i = 0; i < 16; i++) ref16[i] = obs[i].rgb0;
    end

    // Same first frame with 3 idle cycles between pixels
    obs.delete();
    for (int i = 0; i < 16; i++) begin
      send(pix[i], i == 0);
      idle(3);
    end
    idle(2);
    chk("gap_count", 32'(obs.size()), 32'd16);
    if (obs.size() == 16) begin
      foreach (obs[i]) chk($sformatf("gap_rgb[%0d]", i), 32'(obs[i].rgb0), 32'(ref16[i]));
    end

    // Mid-frame restart coincident with a valid pixel
    obs.delete();
    for (int i = 0; i < 6; i++) send(8'($urandom), i == 0);
    send(8'h33, 1'b1);
    for (int i = 0; i < 15; i++) send(8'($urandom), 1'b0);
    idle(4);
    chk("restart_count", 32'(obs.size()), 32'd22);
    if (obs.size() == 22) begin
      chk("restart_rgb", 32'(obs[6].rgb0), 32'h333333);
      chk("restart_eof", 32'(obs[21].eof), 32'd1);
      eof_early = 0;
      for (int i = 0; i < 21; i++) eof_early += int'(obs[i].eof);
      chk("restart_no_early_eof", 32'(eof_early), 32'd0);
    end

    // Random traffic with sporadic frame_start and one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_n  = 1'b0;
        in_valid = 1'b1;
        idle(2);
        reset_n  = 1'b1;
      end
      in_valid    = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 49) == 0);
      in_pixel    = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    frame_start = 1'b0;
    idle(5);
    chk("sb_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
